// File: rtl/pkt_tx_arb_pkg.sv
// Shared types and constants for the packet transmit arbiter.
package pkt_tx_arb_pkg;

  localparam int MOD_W = 3;
  localparam logic [MOD_W-1:0] MOD_FULL = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pkt_rr_select.sv
// Combinational round-robin picker: first requester after the last grant, wrapping.
module pkt_rr_select #(
  parameter int NUM_SRC = 4,
  localparam int ID_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = 0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_SRC;
      if (req[idx]) begin
        winner = ID_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the single xgmii pkt_tx port.
module pkt_tx_arbiter
  import pkt_tx_arb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_W     = 64,
  parameter int GAP_CYCLES = 0,
  localparam int ID_W = $clog2(NUM_SRC)
) (
  input  logic                      clk_156m25,
  input  logic                      reset_156m25,
  input  logic [NUM_SRC-1:0]        src_val,
  input  logic [NUM_SRC-1:0]        src_sop,
  input  logic [NUM_SRC-1:0]        src_eop,
  input  logic [MOD_W*NUM_SRC-1:0]  src_mod,
  input  logic [DATA_W*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      pkt_tx_val,
  output logic                      pkt_tx_sop,
  output logic                      pkt_tx_eop,
  output logic [MOD_W-1:0]          pkt_tx_mod,
  output logic [DATA_W-1:0]         pkt_tx_data,
  input  logic                      pkt_tx_full,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      proto_err
);

  arb_state_t        state_q;
  logic [3:0]        gap_cnt_q;
  logic              first_q;
  logic [ID_W-1:0]   grant_q;
  logic              err_q;

  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    rr_winner;
  logic               rr_any;

  logic               val_p0;
  logic               sop_p0;
  logic               eop_p0;
  logic [MOD_W-1:0]   mod_p0;
  logic [DATA_W-1:0]  data_p0;
  logic               acc_p0;

  logic               tx_val_p1;
  logic               tx_sop_p1;
  logic               tx_eop_p1;
  logic [MOD_W-1:0]   tx_mod_p1;
  logic [DATA_W-1:0]  tx_data_p1;

  assign eligible = src_val & src_sop;

  pkt_rr_select #(.NUM_SRC(NUM_SRC)) u_rr (
    .req    (eligible),
    .last   (grant_q),
    .winner (rr_winner),
    .any    (rr_any)
  );

  // Stage p0: mux the granted source and decide acceptance.
  assign val_p0  = src_val[grant_q];
  assign sop_p0  = src_sop[grant_q];
  assign eop_p0  = src_eop[grant_q];
  assign mod_p0  = src_mod[int'(grant_q)*MOD_W +: MOD_W];
  assign data_p0 = src_data[int'(grant_q)*DATA_W +: DATA_W];
  assign acc_p0  = (state_q == XFER) && val_p0 && !pkt_tx_full;

  always_comb begin
    src_ready = '0;
    if (state_q == XFER && !pkt_tx_full) src_ready[grant_q] = 1'b1;
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      first_q   <= 1'b0;
      grant_q   <= ID_W'(NUM_SRC - 1);
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rr_any) begin
            grant_q <= rr_winner;
            first_q <= 1'b1;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (acc_p0) begin
            first_q <= 1'b0;
            if (sop_p0 && !first_q) err_q <= 1'b1;
            if (eop_p0) begin
              if (GAP_CYCLES > 0) begin
                gap_cnt_q <= '0;
                state_q   <= GAP;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
            gap_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage p1: registered copy of the accepted word; SOP only on the grant's first word.
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      tx_val_p1  <= 1'b0;
      tx_sop_p1  <= 1'b0;
      tx_eop_p1  <= 1'b0;
      tx_mod_p1  <= '0;
      tx_data_p1 <= '0;
    end else begin
      tx_val_p1 <= acc_p0;
      tx_sop_p1 <= acc_p0 && sop_p0 && first_q;
      tx_eop_p1 <= acc_p0 && eop_p0;
      tx_mod_p1 <= (acc_p0 && eop_p0) ? mod_p0 : '0;
      if (acc_p0) tx_data_p1 <= data_p0;
    end
  end

  assign pkt_tx_val  = tx_val_p1;
  assign pkt_tx_sop  = tx_sop_p1;
  assign pkt_tx_eop  = tx_eop_p1;
  assign pkt_tx_mod  = tx_mod_p1;
  assign pkt_tx_data = tx_data_p1;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE);
  assign proto_err   = err_q;

endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Bench for pkt_tx_arbiter: two instances (gap 0 and gap 3) against a queue-based packet model.
module tb_pkt_tx_arbiter;
  import pkt_tx_arb_pkg::*;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int NI = 2;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  typedef struct packed {
    int          cyc;
    logic [1:0]  gid;
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NS-1:0]    src_val  [NI];
  logic [NS-1:0]    src_sop  [NI];
  logic [NS-1:0]    src_eop  [NI];
  logic [3*NS-1:0]  src_mod  [NI];
  logic [DW*NS-1:0] src_data [NI];
  logic [NS-1:0]    src_ready[NI];
  logic             full     [NI];
  logic             tx_val   [NI];
  logic             tx_sop   [NI];
  logic             tx_eop   [NI];
  logic [2:0]       tx_mod   [NI];
  logic [DW-1:0]    tx_data  [NI];
  logic [1:0]       grant    [NI];
  logic             busy     [NI];
  logic             perr     [NI];

  always #5 clk = ~clk;

  pkt_tx_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .GAP_CYCLES(0)) dut0 (
    .clk_156m25(clk), .reset_156m25(rst),
    .src_val(src_val[0]), .src_sop(src_sop[0]), .src_eop(src_eop[0]),
    .src_mod(src_mod[0]), .src_data(src_data[0]), .src_ready(src_ready[0]),
    .pkt_tx_val(tx_val[0]), .pkt_tx_sop(tx_sop[0]), .pkt_tx_eop(tx_eop[0]),
    .pkt_tx_mod(tx_mod[0]), .pkt_tx_data(tx_data[0]), .pkt_tx_full(full[0]),
    .grant_id(grant[0]), .busy(busy[0]), .proto_err(perr[0])
  );

  pkt_tx_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .GAP_CYCLES(3)) dut3 (
    .clk_156m25(clk), .reset_156m25(rst),
    .src_val(src_val[1]), .src_sop(src_sop[1]), .src_eop(src_eop[1]),
    .src_mod(src_mod[1]), .src_data(src_data[1]), .src_ready(src_ready[1]),
    .pkt_tx_val(tx_val[1]), .pkt_tx_sop(tx_sop[1]), .pkt_tx_eop(tx_eop[1]),
    .pkt_tx_mod(tx_mod[1]), .pkt_tx_data(tx_data[1]), .pkt_tx_full(full[1]),
    .grant_id(grant[1]), .busy(busy[1]), .proto_err(perr[1])
  );

  function automatic int gap_of(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  word_t q [NI][NS][$];
  obs_t  olog [NI][$];

  int          owner[NI], gap_left[NI], last[NI];
  bit          first[NI], m_perr[NI];
  bit          e_val[NI], e_sop[NI], e_eop[NI];
  logic [2:0]  e_mod[NI];
  logic [63:0] e_data[NI];
  bit          started = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          rst_req = 1'b1;
  int          full_force[NI];
  bit          rnd_full = 1'b0, rnd_drop = 1'b0, rnd_noise = 1'b0;

  word_t       hw;
  obs_t        ob;
  logic [NS-1:0] exp_rdy;
  int          acc, sidx;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle: check registered outputs, drive the sources, then step the model.
  always @(negedge clk) begin
    cyc++;
    if (started) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("tx_val%0d", k), 64'(tx_val[k]), 64'(e_val[k]));
        if (e_val[k]) chk($sformatf("tx_data%0d", k), tx_data[k], e_data[k]);
        chk($sformatf("tx_sop%0d", k), 64'(tx_sop[k]), 64'(e_sop[k]));
        chk($sformatf("tx_eop%0d", k), 64'(tx_eop[k]), 64'(e_eop[k]));
        chk($sformatf("tx_mod%0d", k), 64'(tx_mod[k]), 64'(e_mod[k]));
        chk($sformatf("busy%0d", k), 64'(busy[k]), 64'(owner[k] >= 0 || gap_left[k] > 0));
        chk($sformatf("grant%0d", k), 64'(grant[k]), 64'(last[k]));
        chk($sformatf("perr%0d", k), 64'(perr[k]), 64'(m_perr[k]));
        if (tx_val[k]) begin
          ob.cyc = cyc; ob.gid = grant[k]; ob.data = tx_data[k];
          ob.sop = tx_sop[k]; ob.eop = tx_eop[k]; ob.mod = tx_mod[k];
          olog[k].push_back(ob);
        end
      end
    end
    rst = rst_req;
    for (int k = 0; k < NI; k++) begin
      if (full_force[k] > 0) begin
        full[k] = 1'b1;
        full_force[k]--;
      end else begin
        full[k] = rnd_full && ($urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < NS; i++) begin
        if (q[k][i].size() > 0 && !(rnd_drop && $urandom_range(0, 4) == 0)) begin
          hw = q[k][i][0];
          src_val[k][i] = 1'b1;
          src_sop[k][i] = hw.sop;
          src_eop[k][i] = hw.eop;
          src_mod[k][i*3 +: 3] = hw.mod;
          src_data[k][i*DW +: DW] = hw.data;
        end else begin
          src_val[k][i] = rnd_noise && q[k][i].size() == 0 && owner[k] != i &&
                          $urandom_range(0, 2) == 0;
          src_sop[k][i] = 1'b0;
          src_eop[k][i] = rnd_noise && $urandom_range(0, 1) == 1;
          src_mod[k][i*3 +: 3] = 3'($urandom);
          src_data[k][i*DW +: DW] = {$urandom, $urandom};
        end
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        owner[k] = -1; gap_left[k] = 0; last[k] = NS - 1;
        first[k] = 1'b0; m_perr[k] = 1'b0;
        e_val[k] = 1'b0; e_sop[k] = 1'b0; e_eop[k] = 1'b0; e_mod[k] = 3'd0; e_data[k] = '0;
        for (int i = 0; i < NS; i++) q[k][i].delete();
        started = 1'b1;
      end else if (started) begin
        exp_rdy = '0;
        acc = -1;
        e_val[k] = 1'b0; e_sop[k] = 1'b0; e_eop[k] = 1'b0; e_mod[k] = 3'd0;
        if (owner[k] >= 0) begin
          if (!full[k]) begin
            exp_rdy[owner[k]] = 1'b1;
            if (src_val[k][owner[k]]) acc = owner[k];
          end
        end else if (gap_left[k] > 0) begin
          gap_left[k]--;
        end else begin
          for (int j = 1; j <= NS; j++) begin
            sidx = (last[k] + j) % NS;
            if (owner[k] < 0 && src_val[k][sidx] && src_sop[k][sidx]) begin
              owner[k] = sidx; last[k] = sidx; first[k] = 1'b1;
            end
          end
        end
        chk($sformatf("src_ready%0d", k), 64'(src_ready[k]), 64'(exp_rdy));
        if (acc >= 0) begin
          hw = q[k][acc].pop_front();
          e_val[k] = 1'b1;
          e_data[k] = hw.data;
          e_sop[k] = hw.sop && first[k];
          e_eop[k] = hw.eop;
          e_mod[k] = hw.eop ? hw.mod : 3'd0;
          if (hw.sop && !first[k]) m_perr[k] = 1'b1;
          first[k] = 1'b0;
          if (hw.eop) begin
            owner[k] = -1;
            gap_left[k] = gap_of(k);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(int k, int s, logic [63:0] d, logic sop, logic eop, logic [2:0] m);
    word_t w;
    w.data = d; w.sop = sop; w.eop = eop; w.mod = m;
    q[k][s].push_back(w);
  endtask

  task automatic push_pkt(int k, int s, int n, logic [63:0] base, int midsop, logic [2:0] m);
    for (int w = 0; w < n; w++)
      push_word(k, s, base + 64'(w), (w == 0) || (w == midsop), w == n - 1,
                (w == n - 1) ? m : 3'($urandom));
  endtask

  function automatic bit idle_all();
    bit r;
    r = 1'b1;
    for (int k = 0; k < NI; k++) begin
      if (owner[k] >= 0 || gap_left[k] > 0) r = 1'b0;
      for (int i = 0; i < NS; i++) if (q[k][i].size() > 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_drain(int bound);
    int n;
    n = 0;
    while (!idle_all() && n < bound) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(idle_all()), 64'd1);
    repeat (6) tick();
  endtask

  task automatic chk_reset_state(string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_grant%0d", tag, k), 64'(grant[k]), 64'd3);
      chk($sformatf("%s_busy%0d", tag, k), 64'(busy[k]), 64'd0);
      chk($sformatf("%s_perr%0d", tag, k), 64'(perr[k]), 64'd0);
      chk($sformatf("%s_val%0d", tag, k), 64'(tx_val[k]), 64'd0);
      chk($sformatf("%s_rdy%0d", tag, k), 64'(src_ready[k]), 64'd0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int nw;
    int ms;
    for (int k = 0; k < NI; k++) begin
      full_force[k] = 0; owner[k] = -1; gap_left[k] = 0; last[k] = NS - 1;
      src_val[k] = '0; src_sop[k] = '0; src_eop[k] = '0;
      src_mod[k] = '0; src_data[k] = '0; full[k] = 1'b0;
    end
    repeat (3) tick();
    rst_req = 1'b0;
    tick();
    tick();
    chk_reset_state("rst");

    // Sources 0 and 2 each with two 2-word packets: grants 0,2,0,2.
    for (int k = 0; k < NI; k++) begin
      olog[k].delete();
      push_pkt(k, 0, 2, 64'h0A00, -1, 3'd1);
      push_pkt(k, 0, 2, 64'h0B00, -1, 3'd2);
      push_pkt(k, 2, 2, 64'h2A00, -1, 3'd3);
      push_pkt(k, 2, 2, 64'h2B00, -1, 3'd4);
    end
    wait_drain(200);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rr_cnt%0d", k), 64'(olog[k].size()), 64'd8);
      if (olog[k].size() == 8) begin
        chk($sformatf("rr_g0_%0d", k), 64'(olog[k][0].gid), 64'd0);
        chk($sformatf("rr_g1_%0d", k), 64'(olog[k][2].gid), 64'd2);
        chk($sformatf("rr_g2_%0d", k), 64'(olog[k][4].gid), 64'd0);
        chk($sformatf("rr_g3_%0d", k), 64'(olog[k][6].gid), 64'd2);
        chk($sformatf("rr_gap%0d", k), 64'(olog[k][2].cyc - olog[k][1].cyc), (k == 0) ? 64'd2 : 64'd5);
        chk($sformatf("rr_d3_%0d", k), olog[k][3].data, 64'h2A01);
      end
    end

    // Single 3-word packet on source 0.
    olog[0].delete();
    n0 = cyc;
    push_word(0, 0, 64'hAABBCCDDEEFF0011, 1'b1, 1'b0, 3'd7);
    push_word(0, 0, 64'h1122334455667788, 1'b0, 1'b0, 3'd7);
    push_word(0, 0, 64'hFFEEDDCCBBAA9988, 1'b0, 1'b1, MOD_FULL);
    wait_drain(100);
    chk("t1_cnt", 64'(olog[0].size()), 64'd3);
    if (olog[0].size() == 3) begin
      chk("t1_lat", 64'(olog[0][0].cyc - n0), 64'd3);
      chk("t1_d0", olog[0][0].data, 64'hAABBCCDDEEFF0011);
      chk("t1_d1", olog[0][1].data, 64'h1122334455667788);
      chk("t1_d2", olog[0][2].data, 64'hFFEEDDCCBBAA9988);
      chk("t1_sop", 64'({olog[0][0].sop, olog[0][1].sop, olog[0][2].sop}), 64'b100);
      chk("t1_eop", 64'({olog[0][0].eop, olog[0][1].eop, olog[0][2].eop}), 64'b001);
      chk("t1_mod", 64'({olog[0][0].mod, olog[0][1].mod, olog[0][2].mod}), 64'd0);
      chk("t1_span", 64'(olog[0][2].cyc - olog[0][0].cyc), 64'd2);
    end

    // Backpressure for 5 cycles after the first word.
    olog[0].delete();
    push_pkt(0, 1, 4, 64'h1000, -1, 3'd6);
    tick();
    tick();
    full_force[0] = 5;
    wait_drain(100);
    chk("bp_cnt", 64'(olog[0].size()), 64'd4);
    if (olog[0].size() == 4) begin
      chk("bp_hole", 64'(olog[0][1].cyc - olog[0][0].cyc), 64'd6);
      for (int w = 0; w < 4; w++)
        chk($sformatf("bp_d%0d", w), olog[0][w].data, 64'h1000 + 64'(w));
    end

    // SOP repeated on word 2 of a 4-word packet.
    olog[0].delete();
    push_pkt(0, 3, 4, 64'h3000, 1, 3'd2);
    wait_drain(100);
    chk("pe_cnt", 64'(olog[0].size()), 64'd4);
    if (olog[0].size() == 4)
      chk("pe_sop", 64'({olog[0][0].sop, olog[0][1].sop, olog[0][2].sop, olog[0][3].sop}), 64'b1000);
    chk("pe_err0", 64'(perr[0]), 64'd1);
    chk("pe_err1", 64'(perr[1]), 64'd0);

    // Two queued single-word packets, mod 5.
    for (int k = 0; k < NI; k++) begin
      olog[k].delete();
      push_word(k, 1, 64'h5001, 1'b1, 1'b1, 3'd5);
      push_word(k, 1, 64'h5002, 1'b1, 1'b1, 3'd5);
    end
    wait_drain(100);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("sw_cnt%0d", k), 64'(olog[k].size()), 64'd2);
      if (olog[k].size() == 2) begin
        chk($sformatf("sw_gap%0d", k), 64'(olog[k][1].cyc - olog[k][0].cyc), (k == 0) ? 64'd2 : 64'd5);
        chk($sformatf("sw_mod%0d", k), 64'({olog[k][0].mod, olog[k][1].mod}), 64'o55);
        chk($sformatf("sw_se%0d", k), 64'({olog[k][0].sop, olog[k][0].eop, olog[k][1].sop, olog[k][1].eop}), 64'hF);
      end
    end

    // Randomised traffic with stalls, source drops and ungranted non-SOP noise.
    rnd_full = 1'b1; rnd_drop = 1'b1; rnd_noise = 1'b1;
    for (int p = 0; p < 80; p++) begin
      nw = $urandom_range(1, 5);
      ms = (nw > 1 && $urandom_range(0, 15) == 0) ? $urandom_range(1, nw - 1) : -1;
      push_pkt($urandom_range(0, NI - 1), $urandom_range(0, NS - 1), nw,
               {$urandom, $urandom}, ms, 3'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain(20000);
    rnd_full = 1'b0; rnd_drop = 1'b0; rnd_noise = 1'b0;
    repeat (4) tick();

    // Reset while word 2 of a 4-word packet is presented.
    for (int k = 0; k < NI; k++) begin
      olog[k].delete();
      push_pkt(k, 1, 4, 64'h7000, -1, 3'd3);
    end
    tick();
    tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    chk_reset_state("mid_rst");
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("mid_cnt%0d", k), 64'(olog[k].size()), 64'd1);
      olog[k].delete();
      push_word(k, 0, 64'h8000, 1'b1, 1'b1, 3'd1);
      push_word(k, 1, 64'h8001, 1'b1, 1'b1, 3'd2);
    end
    wait_drain(100);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("post_cnt%0d", k), 64'(olog[k].size()), 64'd2);
      if (olog[k].size() == 2) begin
        chk($sformatf("post_g0_%0d", k), 64'(olog[k][0].gid), 64'd0);
        chk($sformatf("post_g1_%0d", k), 64'(olog[k][1].gid), 64'd1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pkt_tx_arbiter.md
# pkt_tx_arbiter

Packet-granular round-robin arbiter that shares the single `pkt_tx_*` input of the `xgmii` transmit core among `NUM_SRC` packet sources. It grants one source at a time from SOP to EOP, forwards that source's words through one register stage, honours `pkt_tx_full` backpressure and inserts an optional idle gap between packets. It sits in the `clk_156m25` domain directly in front of `xgmii`.

## Interface
- `NUM_SRC`, default 4: number of requesters, 2..8.
- `DATA_W`, default 64: packet word width.
- `GAP_CYCLES`, default 0: extra idle cycles inserted after each EOP, 0..15.
- `clk_156m25`, in, 1: sole clock.
- `reset_156m25`, in, 1: reset. One clock; reset is synchronous and active-high.
- `src_val`, in, NUM_SRC: per-source word valid.
- `src_sop`, in, NUM_SRC: per-source start of packet.
- `src_eop`, in, NUM_SRC: per-source end of packet.
- `src_mod`, in, 3*NUM_SRC: per-source byte modulus, meaningful with EOP only.
- `src_data`, in, DATA_W*NUM_SRC: per-source data; source i occupies slice [i*DATA_W +: DATA_W].
- `src_ready`, out, NUM_SRC: word accepted from source i when `src_val[i] & src_ready[i]`.
- `pkt_tx_val`, `pkt_tx_sop`, `pkt_tx_eop`, out, 1 each: to `xgmii`.
- `pkt_tx_mod`, out, 3: to `xgmii`.
- `pkt_tx_data`, out, DATA_W: to `xgmii`.
- `pkt_tx_full`, in, 1: backpressure from the `xgmii` TX FIFO.
- `grant_id`, out, clog2(NUM_SRC): currently or last granted source.
- `busy`, out, 1: high when not in IDLE.
- `proto_err`, out, 1: sticky; set on a SOP received mid-packet from the granted source.

## Operation
- FSM states:
  - IDLE: when any source is eligible (`src_val[i] & src_sop[i]`), pick the winner with `pkt_rr_select`, register `grant_id`, go to XFER. Otherwise stay.
  - XFER: `src_ready[grant_id] = !pkt_tx_full`; all other readies are 0. When the EOP word is accepted, go to GAP if `GAP_CYCLES>0`, else go to IDLE.
  - GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- Round-robin search starts at `grant_id+1` and wraps modulo NUM_SRC. After reset the pointer is NUM_SRC-1, so source 0 has first priority.
- A source presenting `val` without `sop` while ungranted is not eligible and is never granted. No error is flagged.
- Forwarding: each accepted word is registered onto the `pkt_tx_*` outputs the next cycle.
  - `pkt_tx_val` is 1 only on cycles after an acceptance.
  - `pkt_tx_sop` is set on the first accepted word of the grant only.
  - `pkt_tx_mod` is forced to 0 when EOP=0.
  - Mod 000 on EOP means all 8 bytes are valid.
- SOP on a non-first word of the grant: the word is forwarded with `pkt_tx_sop=0`, the packet continues, and `proto_err` is set. `proto_err` clears only on reset.
- A single-word packet (SOP and EOP on the same word) is legal.
- Reset values: all `src_ready`, `pkt_tx_*`, `busy` and `proto_err` are 0; `grant_id` is NUM_SRC-1; the FSM is in IDLE; the gap counter is 0.
- Reset mid-packet aborts the grant immediately. Downstream sees no EOP; packet truncation is accepted system behaviour.

## Timing
- Request-to-grant latency: eligible request at cycle 0; `grant_id` and XFER at cycle 1; first word accepted at cycle 1; `pkt_tx_sop` at cycle 2.
- Accepted word to `pkt_tx_*` output: exactly 1 cycle.
- Back-to-back packets with `GAP_CYCLES=0`: EOP accepted at cycle k, IDLE at k+1, next SOP accepted at k+2. This gives exactly one idle `pkt_tx_val=0` cycle between packets.
- With `GAP_CYCLES=G`: G+1 idle cycles on `pkt_tx_val` between packets.
- `pkt_tx_full` is sampled combinationally into `src_ready`. While it is high, no word is accepted, and `pkt_tx_val` is 0 from the next cycle.
- The `xgmii` FIFO keeps at least one entry of slack after asserting full, which absorbs the one in-flight registered word.
- A source dropping `src_val` mid-packet stalls the grant indefinitely; there is no timeout.

## Structure
- Package `pkt_tx_arb_pkg`:
  - FSM state enum {IDLE, XFER, GAP}.
  - `MOD_W=3`.
  - Constant `MOD_FULL=3'b000`.
- Sub-module `pkt_rr_select`: combinational round-robin picker. Inputs: request vector and last-grant index. Outputs: winner index and `any` flag.
- The top level holds the FSM, gap counter, output register, mux and `proto_err`.

## Test plan
- Single source 0 sends 3 words (AABBCCDDEEFF0011 SOP, 1122334455667788, FFEEDDCCBBAA9988 EOP with mod 000) -> identical words appear on `pkt_tx_*` 1 cycle after each acceptance; SOP only on the first word, EOP and mod=000 only on the last.
- Sources 0 and 2 both request continuously with 2-word packets -> grants alternate 0,2,0,2. With `GAP_CYCLES=0`, exactly 1 idle cycle separates packets.
- `pkt_tx_full` held high for 5 cycles mid-packet -> `src_ready` is 0 for those 5 cycles; `pkt_tx_val` is 0 for 5 cycles starting one cycle later; no word is lost or duplicated.
- Granted source asserts SOP on word 2 of a 4-word packet -> forwarded with `pkt_tx_sop=0`, 4 words total, `proto_err` rises and stays high.
- `GAP_CYCLES=3`, two queued 1-word packets (SOP and EOP together, mod=5) -> 4 idle cycles between them; mod=5 is forwarded on both.
- Reset asserted during word 2 of a 4-word packet -> the next cycle shows all outputs at reset values. After release, source 0 wins against simultaneous requests from 0 and 1.
